// File: rtl/edge_slope_setup.sv
// Triangle-setup sequencer: forms dx/dy for the three edges, issues one divide per
// non-horizontal edge to the shared divider and hands the slope set to the rasterizer.
module edge_slope_setup #(
    parameter int W    = 21,
    parameter int CW   = 10,
    parameter int FRAC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tri_valid,
    output logic          tri_ready,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y1,
    input  logic [CW-1:0] x2,
    input  logic [CW-1:0] y2,
    output logic          div_open,
    output logic [W-1:0]  div_dividend,
    output logic [W-1:0]  div_divisor,
    input  logic          div_finish,
    input  logic [W-1:0]  div_quotient,
    output logic          slope_valid,
    input  logic          slope_ready,
    output logic [W-1:0]  slope0,
    output logic [W-1:0]  slope1,
    output logic [W-1:0]  slope2,
    output logic [2:0]    horiz
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        NEXT,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    edge_idx;
    logic [CW-1:0] cx0, cy0, cx1, cy1, cx2, cy2;

    logic [CW-1:0] xa, ya, xb, yb;
    logic [CW:0]   dx, dy;
    logic [W-1:0]  dividend_next, divisor_next;
    logic          wr_en;
    logic [W-1:0]  wr_val;

    // Edge endpoints: e0 = v0->v1, e1 = v1->v2, e2 = v0->v2.
    always_comb begin
        xa = cx0;
        ya = cy0;
        xb = cx1;
        yb = cy1;
        case (edge_idx)
            2'd1: begin
                xa = cx1;
                ya = cy1;
                xb = cx2;
                yb = cy2;
            end
            2'd2: begin
                xa = cx0;
                ya = cy0;
                xb = cx2;
                yb = cy2;
            end
            default: ;
        endcase
    end

    assign dx            = {1'b0, xb} - {1'b0, xa};
    assign dy            = {1'b0, yb} - {1'b0, ya};
    assign dividend_next = {{(W-CW-1-FRAC){dx[CW]}}, dx, {FRAC{1'b0}}};
    assign divisor_next  = {{(W-CW-1){dy[CW]}}, dy};

    // A slope is written either as zero for a horizontal edge or from a fresh quotient.
    always_comb begin
        wr_en  = 1'b0;
        wr_val = div_quotient;
        if (state == ISSUE && div_divisor == '0) begin
            wr_en  = 1'b1;
            wr_val = '0;
        end else if (state == WAIT_DONE && div_finish) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            edge_idx     <= 2'd0;
            tri_ready    <= 1'b0;
            div_open     <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            slope_valid  <= 1'b0;
            slope0       <= '0;
            slope1       <= '0;
            slope2       <= '0;
            horiz        <= 3'b000;
            cx0          <= '0;
            cy0          <= '0;
            cx1          <= '0;
            cy1          <= '0;
            cx2          <= '0;
            cy2          <= '0;
        end else begin
            div_open <= 1'b0;
            if (wr_en) begin
                case (edge_idx)
                    2'd0:    slope0 <= wr_val;
                    2'd1:    slope1 <= wr_val;
                    default: slope2 <= wr_val;
                endcase
            end
            case (state)
                IDLE: begin
                    if (tri_ready && tri_valid) begin
                        cx0       <= x0;
                        cy0       <= y0;
                        cx1       <= x1;
                        cy1       <= y1;
                        cx2       <= x2;
                        cy2       <= y2;
                        horiz     <= 3'b000;
                        edge_idx  <= 2'd0;
                        tri_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        tri_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    div_dividend <= dividend_next;
                    div_divisor  <= divisor_next;
                    div_open     <= (dy != '0);
                    state        <= ISSUE;
                end
                ISSUE: begin
                    if (div_divisor == '0) begin
                        horiz[edge_idx] <= 1'b1;
                        state           <= NEXT;
                    end else begin
                        state <= WAIT_ACK;
                    end
                end
                // A finish still high from the previous divide must drop before a result counts.
                WAIT_ACK: begin
                    if (!div_finish) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (div_finish) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (edge_idx == 2'd2) begin
                        slope_valid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        edge_idx <= edge_idx + 2'd1;
                        state    <= SETUP;
                    end
                end
                DONE: begin
                    if (slope_ready) begin
                        slope_valid <= 1'b0;
                        tri_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_slope_setup.sv
// Directed bench for edge_slope_setup with a behavioural divider and a scoreboard
// of expected slope sets computed from the vertex coordinates.
module tb_edge_slope_setup;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [9:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic        div_open;
    logic [20:0] div_dividend, div_divisor;
    logic        div_finish = 1'b1;
    logic [20:0] div_quotient = 21'h0DEAD;
    logic        slope_valid;
    logic        slope_ready = 1'b0;
    logic [20:0] slope0, slope1, slope2;
    logic [2:0]  horiz;

    int errors = 0;
    int checks = 0;
    int open_count = 0;
    int lat_cfg = 5;
    int fall_delay = 1;
    int cnt = 0;
    int fall_cnt = 0;
    logic [20:0] pend_q = '0;

    typedef struct {
        logic [20:0] s0;
        logic [20:0] s1;
        logic [20:0] s2;
        logic [2:0]  h;
    } exp_t;
    exp_t sb[$];

    edge_slope_setup dut (
        .clk(clk), .rst(rst),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .div_open(div_open), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_finish(div_finish), .div_quotient(div_quotient),
        .slope_valid(slope_valid), .slope_ready(slope_ready),
        .slope0(slope0), .slope1(slope1), .slope2(slope2), .horiz(horiz)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] div_model(input logic [20:0] a, input logic [20:0] b);
        logic signed [20:0] sa, sbv;
        sa  = a;
        sbv = b;
        if (sbv == 0) return '0;
        return sa / sbv;
    endfunction

    // Divider: finish falls fall_delay cycles after an open (0 = at the open edge),
    // rises with the quotient after lat_cfg cycles and then holds.
    always @(posedge clk) begin
        if (div_open) begin
            open_count++;
            pend_q   <= div_model(div_dividend, div_divisor);
            cnt      <= lat_cfg;
            fall_cnt <= fall_delay;
            if (fall_delay == 0) div_finish <= 1'b0;
        end else begin
            if (fall_cnt > 0) begin
                fall_cnt <= fall_cnt - 1;
                if (fall_cnt == 1) div_finish <= 1'b0;
            end
            if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    div_finish   <= 1'b1;
                    div_quotient <= pend_q;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [20:0] slope_of(input int xa, input int ya, input int xb, input int yb);
        int dx, dy;
        dx = xb - xa;
        dy = yb - ya;
        if (dy == 0) return '0;
        return 21'((dx * 256) / dy);
    endfunction

    task automatic push_expect(input int ax0, input int ay0, input int ax1, input int ay1,
                               input int ax2, input int ay2);
        exp_t e;
        e.s0 = slope_of(ax0, ay0, ax1, ay1);
        e.s1 = slope_of(ax1, ay1, ax2, ay2);
        e.s2 = slope_of(ax0, ay0, ax2, ay2);
        e.h  = {ay2 == ay0, ay2 == ay1, ay1 == ay0};
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tri_ready"}, tri_ready, 0);
        check({tag, "_div_open"}, div_open, 0);
        check({tag, "_dividend"}, div_dividend, 0);
        check({tag, "_divisor"}, div_divisor, 0);
        check({tag, "_slope_valid"}, slope_valid, 0);
        check({tag, "_slopes"}, slope0 | slope1 | slope2, 0);
        check({tag, "_horiz"}, horiz, 0);
    endtask

    // Wait for ready, present the triangle for one accepted cycle.
    task automatic drive_tri(input string tag, input int ax0, input int ay0, input int ax1,
                             input int ay1, input int ax2, input int ay2);
        int w;
        w = 0;
        while (!tri_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!tri_ready) check({tag, "_ready_timeout"}, 0, 1);
        x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1);
        y1 = 10'(ay1); x2 = 10'(ax2); y2 = 10'(ay2);
        tri_valid = 1'b1;
        @(posedge clk);
        #1;
        tri_valid = 1'b0;
    endtask

    task automatic run_tri(input string tag, input int ax0, input int ay0, input int ax1,
                           input int ay1, input int ax2, input int ay2, input int exp_opens,
                           input int exp_lat, input int hold, input bit inject);
        int cyc, opens0, bad;
        exp_t e;
        push_expect(ax0, ay0, ax1, ay1, ax2, ay2);
        opens0 = open_count;
        drive_tri(tag, ax0, ay0, ax1, ay1, ax2, ay2);
        cyc = 1;
        check({tag, "_busy"}, tri_ready, 0);
        while (!slope_valid && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_valid_seen"}, slope_valid, 1);
        if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_opens"}, open_count - opens0, exp_opens);
        e = sb.pop_front();
        check({tag, "_slope0"}, slope0, e.s0);
        check({tag, "_slope1"}, slope1, e.s1);
        check({tag, "_slope2"}, slope2, e.s2);
        check({tag, "_horiz"}, horiz, e.h);
        if (!slope_ready) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                if (inject && i < 3) begin
                    x1 = 10'd900; y1 = 10'd700; tri_valid = 1'b1;
                end else begin
                    tri_valid = 1'b0;
                end
                @(posedge clk);
                #1;
                if (slope_valid !== 1'b1 || tri_ready !== 1'b0 || slope0 !== e.s0 ||
                    slope1 !== e.s1 || slope2 !== e.s2 || horiz !== e.h || div_open !== 1'b0)
                    bad++;
            end
            tri_valid = 1'b0;
            check({tag, "_hold_stable"}, bad, 0);
            slope_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        slope_ready = 1'b0;
        check({tag, "_valid_drop"}, slope_valid, 0);
        check({tag, "_idle_ready"}, tri_ready, 1);
    endtask

    initial begin
        int opens0;
        $display("[TB] edge_slope_setup bench start");
        // Reset with a stale divider finish already high.
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release_ready", tri_ready, 1);

        run_tri("t1", 0, 0, 4, 2, 10, 2, 2, -1, 0, 0);
        check("t1_e2_value", slope_of(0, 0, 10, 2), 1280);

        fall_delay  = 0;
        slope_ready = 1'b1;
        run_tri("t2_early_ready", 8, 0, 0, 4, 8, 4, 2, -1, 0, 0);

        run_tri("degenerate", 5, 5, 5, 5, 5, 5, 0, 10, 20, 1);
        opens0 = open_count;
        repeat (4) @(posedge clk);
        #1;
        check("no_ghost_tri_valid", slope_valid, 0);
        check("no_ghost_opens", open_count - opens0, 0);

        lat_cfg    = 22;
        fall_delay = 1;
        run_tri("stale_finish", 0, 0, 3, 7, 100, 3, 3, -1, 2, 0);

        // Reset while the e1 divide is outstanding.
        opens0 = open_count;
        drive_tri("abort", 0, 0, 2, 5, 9, 1);
        for (int i = 0; i < 200 && open_count - opens0 < 2; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort_e1_open", open_count - opens0, 2);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        opens0 = open_count;
        repeat (30) @(posedge clk);
        #1;
        check("late_finish_arrived", div_finish, 1);
        check("late_finish_ignored_valid", slope_valid, 0);
        check("late_finish_ignored_opens", open_count - opens0, 0);
        lat_cfg = 3;
        run_tri("after_reset", 1, 2, 7, 9, 3, 4, 3, -1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/edge_slope_setup.md
Name: edge_slope_setup

Overview:
- Triangle-setup sequencer directly upstream of divider_21bits in the render pipeline; also consumes its results.
- Accepts one triangle (three screen-space vertices) and forms dx/dy for edges e0 = v0->v1, e1 = v1->v2 and e2 = v0->v2.
- Issues one divide per non-horizontal edge to the shared divider over its open/finish handshake.
- Collects the three signed fixed-point slopes (dx/dy) and presents them to the rasterizer with a valid/ready handshake.

Parameters:
- W, 21, divider operand/quotient width; fixed by divider_21bits.
- CW, 10, unsigned vertex coordinate width.
- FRAC, 8, fractional bits of slope; dividend = dx << FRAC. Requires CW+1+FRAC <= W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tri_valid  in  1  triangle vertices valid.
- tri_ready  out  1  block idle, accepting a triangle.
- x0,y0,x1,y1,x2,y2  in  CW each  unsigned vertex coordinates.
- div_open  out  1  divider start pulse.
- div_dividend  out  W  signed dx << FRAC.
- div_divisor  out  W  signed dy, sign-extended.
- div_finish  in  1  divider result valid.
- div_quotient  in  W  signed divider result.
- slope_valid  out  1  slope set valid.
- slope_ready  in  1  rasterizer accepts slope set.
- slope0,slope1,slope2  out  W each  signed slopes for e0, e1, e2 (FRAC fractional bits).
- horiz  out  3  bit i = 1: edge i has dy == 0.

Behaviour:
- Reset: state IDLE; edge counter 0; tri_ready=0 during the reset cycle, then 1 in IDLE; div_open=0; div_dividend=div_divisor=0; slope_valid=0; slope0..2=0; horiz=0.
- Divider contract: div_finish falls within one cycle after a div_open pulse. It rises when div_quotient is valid and holds until the next div_open. div_quotient is truncated toward zero.
- Arithmetic: dx = xb - xa and dy = yb - ya, both signed CW+1 bits. div_dividend = sign-extended dx shifted left FRAC. div_divisor = sign-extended dy. Operands are registered and held stable from the open cycle until capture.
- States and transitions:
  - IDLE: tri_ready=1. On tri_valid, latch all six coordinates, clear horiz, set edge=0 -> SETUP. tri_valid while not IDLE is ignored.
  - SETUP (1 cycle): register dx/dy for the current edge -> ISSUE.
  - ISSUE (1 cycle): if dy == 0, write slope[edge]=0 and horiz[edge]=1, with no div_open -> NEXT. Otherwise assert div_open=1 for exactly this cycle -> WAIT_ACK.
  - WAIT_ACK: wait for div_finish==0 -> WAIT_DONE. This rejects a stale finish from a previous divide.
  - WAIT_DONE: when div_finish==1, capture div_quotient into slope[edge] -> NEXT.
  - NEXT: if edge==2 -> DONE, else edge++ -> SETUP.
  - DONE: slope_valid=1. slope0..2 and horiz are held stable until slope_ready==1 in the same cycle. On that handshake, slope_valid drops the next cycle -> IDLE.
- Latency: non-horizontal edge = 3 cycles plus divider time; horizontal edge = 3 cycles. With all edges horizontal, tri accept to slope_valid = 10 cycles.
- Each triangle produces exactly one div_open pulse per non-horizontal edge, in edge order e0, e1, e2.
- Boundary cases:
  - Degenerate triangle (all vertices identical): all horiz bits = 1, all slopes = 0, no divides issued.
  - Reset in any state, including WAIT_*: returns to IDLE immediately. The in-flight divider result is discarded, and any later div_finish is ignored until a new divide is issued.
  - slope_ready asserted outside DONE has no effect.

Test Plan:
- v0(0,0), v1(4,2), v2(10,2), FRAC=8 -> two div_open pulses. slope0=512 (dividend 1024, divisor 2); slope1=0 with horiz=3'b010; slope2=1280; slope_valid asserted once.
- v0(8,0), v1(0,4), v2(8,4) -> slope0=-512 (21'h1FFE00); horiz=3'b010; slope2=0 from dx=0, dy=4 with a divide still issued (horiz[2]=0).
- All vertices (5,5) -> zero div_open pulses, horiz=3'b111, slopes 0, slope_valid 10 cycles after acceptance.
- Hold slope_ready=0 for 20 cycles in DONE -> outputs stable, tri_ready=0, and a second tri_valid is ignored. Raise slope_ready -> one-cycle handshake, return to IDLE.
- Divider model holding div_finish=1 from a prior op, latency 22 cycles -> slope captured only after finish falls and rises again; no stale quotient captured.
- Assert rst during WAIT_DONE of e1 -> next cycle all outputs at reset values. A following triangle completes correctly with the late finish ignored.
